// File: rtl/vmac_pkg.sv
// Shared encodings for the vector multiply-accumulate unit: op codes, FSM states
// and the element-width legality check used at elaboration.
package vmac_pkg;

  typedef enum logic [1:0] {
    OP_MACC  = 2'b00,
    OP_NMSAC = 2'b01,
    OP_MUL   = 2'b10,
    OP_MOVE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic bit sew_legal(input int sew);
    return (sew == 8) || (sew == 16) || (sew == 32) || (sew == 64);
  endfunction

endpackage

// File: rtl/vmac_lane.sv
// One combinational multiply-accumulate lane: a*b +/- vd, a*b alone, or vd passthrough.
// A disabled lane (masked element) returns vd untouched.
module vmac_lane
  import vmac_pkg::*;
#(
  parameter int SEW = 32
) (
  input  op_e            op_i,
  input  logic           en_i,
  input  logic [SEW-1:0] a_i,
  input  logic [SEW-1:0] b_i,
  input  logic [SEW-1:0] vd_i,
  output logic [SEW-1:0] res_o
);

  // Only the low SEW bits of the product matter, so signedness is irrelevant.
  logic [SEW-1:0] prod;
  assign prod = a_i * b_i;

  always_comb begin
    res_o = vd_i;
    if (en_i) begin
      case (op_i)
        OP_MACC:  res_o = vd_i + prod;
        OP_NMSAC: res_o = vd_i - prod;
        OP_MUL:   res_o = prod;
        default:  res_o = vd_i;
      endcase
    end
  end

endmodule

// File: rtl/vmac_pipe.sv
// Multi-cycle vector MAC: LANES elements per beat, lane results registered one stage
// before landing in the result vector. Define VMAC_MASK_EN to honour vmask.
module vmac_pipe
  import vmac_pkg::*;
#(
  parameter int VL    = 8,
  parameter int SEW   = 32,
  parameter int LANES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [VL*SEW-1:0] vs1,
  input  logic [VL*SEW-1:0] vs2,
  input  logic [VL*SEW-1:0] vd,
  input  logic [VL-1:0]     vmask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VL*SEW-1:0] result_v,
  output logic              busy
);

  localparam int W     = VL * SEW;
  localparam int BEATS = VL / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  if (((VL % LANES) != 0) || !sew_legal(SEW)) begin : g_param_err
    $error("vmac_pipe: VL must be a multiple of LANES and SEW one of 8/16/32/64");
  end

  // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Neither
  // ready depends combinationally on the matching valid.
  state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]         a_q, b_q, vd_q;
  op_e                  op_q;
  logic [W-1:0]         result_q, result_d;
  logic                 pipe_vld_q;
  logic [CNT_W-1:0]     pipe_beat_q;
  logic [LANES*SEW-1:0] pipe_res_q;
  logic [LANES*SEW-1:0] lane_res;
  logic [CNT_W-1:0]     lane_beat;
  logic                 accept, issue, pipe_last;

  assign accept    = in_valid && in_ready;
  assign issue     = (state_q == ST_BUSY) && (cnt_q != CNT_END);
  assign pipe_last = pipe_vld_q && (pipe_beat_q == CNT_LAST);
  assign lane_beat = issue ? cnt_q : '0;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (pipe_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? ST_BUSY : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign result_v  = result_q;

  always_comb begin
    cnt_d = cnt_q;
    if (accept)     cnt_d = '0;
    else if (issue) cnt_d = cnt_q + CNT_W'(1);
  end

`ifdef VMAC_MASK_EN
  logic [VL-1:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask_q <= '0;
    else if (accept) mask_q <= vmask;
  end
`else
  logic unused_vmask;
  assign unused_vmask = ^vmask;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic en_e;
`ifdef VMAC_MASK_EN
    assign en_e = mask_q[int'(lane_beat) * LANES + l];
`else
    assign en_e = 1'b1;
`endif
    vmac_lane #(.SEW(SEW)) u_lane (
      .op_i  (op_q),
      .en_i  (en_e),
      .a_i   (a_q[(int'(lane_beat) * LANES + l) * SEW +: SEW]),
      .b_i   (b_q[(int'(lane_beat) * LANES + l) * SEW +: SEW]),
      .vd_i  (vd_q[(int'(lane_beat) * LANES + l) * SEW +: SEW]),
      .res_o (lane_res[l * SEW +: SEW])
    );
  end

  // Registered lane outputs land in their element slots one cycle after issue.
  always_comb begin
    result_d = result_q;
    if (pipe_vld_q) begin
      for (int l = 0; l < LANES; l++) begin
        result_d[(int'(pipe_beat_q) * LANES + l) * SEW +: SEW] = pipe_res_q[l * SEW +: SEW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      vd_q        <= '0;
      op_q        <= OP_MACC;
      pipe_vld_q  <= 1'b0;
      pipe_beat_q <= '0;
      pipe_res_q  <= '0;
      result_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pipe_vld_q <= issue;
      result_q   <= result_d;
      if (issue) begin
        pipe_beat_q <= cnt_q;
        pipe_res_q  <= lane_res;
      end
      if (accept) begin
        a_q  <= vs1;
        b_q  <= vs2;
        vd_q <= vd;
        op_q <= op_e'(op);
      end
    end
  end

endmodule

// File: tb/tb_vmac_pipe.sv
// Bench for vmac_pipe (VL=8, SEW=32, LANES=2): table vectors, hand-written corner
// sequences and random operations checked against an element-wise arithmetic model.
module tb_vmac_pipe;

  localparam int VL    = 8;
  localparam int SEW   = 32;
  localparam int LANES = 2;
  localparam int W     = VL * SEW;
  localparam int LAT   = VL / LANES + 1;
`ifdef VMAC_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]     op;
  logic [W-1:0]   vs1, vs2, vd, result_v;
  logic [VL-1:0]  vmask;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  vmac_pipe #(.VL(VL), .SEW(SEW), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .vs1       (vs1),
    .vs2       (vs2),
    .vd        (vd),
    .vmask     (vmask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_v  (result_v),
    .busy      (busy)
  );

  typedef struct {
    string          name;
    logic [1:0]     op;
    logic [SEW-1:0] a, b, d, exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [SEW-1:0] x);
    return {VL{x}};
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Element-wise reference: each result element follows the op rule modulo 2^SEW.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] d,
                                         input logic [VL-1:0] m);
    logic [W-1:0]   r;
    logic [SEW-1:0] ea, eb, ed, p;
    for (int i = 0; i < VL; i++) begin
      ea = a[i*SEW +: SEW];
      eb = b[i*SEW +: SEW];
      ed = d[i*SEW +: SEW];
      p  = ea * eb;
      case (o)
        2'b00:   r[i*SEW +: SEW] = ed + p;
        2'b01:   r[i*SEW +: SEW] = ed - p;
        2'b10:   r[i*SEW +: SEW] = p;
        default: r[i*SEW +: SEW] = ed;
      endcase
      if (MASK_ON && !m[i]) r[i*SEW +: SEW] = ed;
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] d, input logic [VL-1:0] m);
    int t = 0;
    op = o; vs1 = a; vs2 = b; vd = d; vmask = m; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); vs1 = rand_vec(); vs2 = rand_vec(); vd = rand_vec();
    vmask = VL'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: out_valid stayed 0 for %0d cycles", lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] ea, eb, a, b, d, hold;
    logic [1:0]   o;
    logic [VL-1:0] m;

    tbl[0] = '{"macc",       2'b00, 32'd3,       32'd5,       32'd7,          32'd22};
    tbl[1] = '{"nmsac_wrap", 2'b01, 32'd1,       32'd2,       32'd0,          32'hFFFF_FFFE};
    tbl[2] = '{"mul_low",    2'b10, 32'h1_0000,  32'h1_0000,  32'h1234_5678,  32'd0};
    tbl[3] = '{"move",       2'b11, 32'd9,       32'd9,       32'hDEAD_BEEF,  32'hDEAD_BEEF};
    tbl[4] = '{"macc_wrap",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'd6};
    tbl[5] = '{"nmsac_neg",  2'b01, 32'd3,       32'd5,       32'd7,          32'hFFFF_FFF8};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00;
    vs1 = '0; vs2 = '0; vd = '0; vmask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk("reset_result", result_v, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].op, rep(tbl[i].a), rep(tbl[i].b), rep(tbl[i].d), '1);
      chk1({tbl[i].name, "_busy"}, busy, 1'b1);
      wait_done(lat);
      chk_int({tbl[i].name, "_latency"}, lat, LAT);
      chk({tbl[i].name, "_result"}, result_v, rep(tbl[i].exp));
    end
    @(posedge clk); #1;
    chk1("idle_out_valid", out_valid, 1'b0);
    chk("idle_result_held", result_v, rep(tbl[5].exp));

    // Backpressure: result must hold while the consumer stalls.
    a = rand_vec(); b = rand_vec(); d = rand_vec();
    hold = model(2'b00, a, b, d, '1);
    out_ready = 1'b0;
    send(2'b00, a, b, d, '1);
    wait_done(lat);
    chk_int("bp_latency", lat, LAT);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_result_stable", result_v, hold);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk1("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk1("bp_release_out_valid", out_valid, 1'b0);

    // Back-to-back: the next bundle is accepted in the DONE cycle.
    a = rand_vec(); b = rand_vec(); d = rand_vec();
    exp_q.push_back(model(2'b00, a, b, d, '1));
    send(2'b00, a, b, d, '1);
    ea = rand_vec(); eb = rand_vec();
    exp_q.push_back(model(2'b01, ea, eb, a, '1));
    op = 2'b01; vs1 = ea; vs2 = eb; vd = a; vmask = '1; in_valid = 1'b1;
    wait_done(lat);
    chk("b2b_first_result", result_v, exp_q.pop_front());
    chk1("b2b_in_ready_done", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("b2b_second_busy", busy, 1'b1);
    wait_done(lat);
    chk_int("b2b_second_latency", lat, LAT);
    chk("b2b_second_result", result_v, exp_q.pop_front());
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    send(2'b00, rand_vec(), rand_vec(), rand_vec(), '1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_result", result_v, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(2'b00, rep(32'd3), rep(32'd5), rep(32'd7), '1);
    wait_done(lat);
    chk_int("postrst_latency", lat, LAT);
    chk("postrst_result", result_v, rep(32'd22));
    @(posedge clk); #1;

`ifdef VMAC_MASK_EN
    begin
      logic [W-1:0] mexp;
      for (int i = 0; i < VL; i++) mexp[i*SEW +: SEW] = (i % 2 == 1) ? 32'd22 : 32'd7;
      send(2'b00, rep(32'd3), rep(32'd5), rep(32'd7), 8'hAA);
      wait_done(lat);
      chk("mask_aa_result", result_v, mexp);
      @(posedge clk); #1;
    end
`endif

    // Random operations with random consumer stalls.
    for (int n = 0; n < 30; n++) begin
      o = 2'($urandom_range(0, 3));
      a = rand_vec(); b = rand_vec(); d = rand_vec();
      m = VL'($urandom);
      exp_q.push_back(model(o, a, b, d, m));
      out_ready = ($urandom_range(0, 1) == 1);
      send(o, a, b, d, m);
      wait_done(lat);
      chk_int("rand_latency", lat, LAT);
      hold = exp_q.pop_front();
      chk("rand_result", result_v, hold);
      if (!out_ready) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        chk("rand_stall_hold", result_v, hold);
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
